capture_sequencer: RTL
======================

// Module: capture_sequencer
// PURPOSE
//  Sequences one ADC capture through the DataStorage block (32-bit sample FIFOs feeding a 32-to-8 width converter).
//  Sequence: clear storage, arm, wait for trigger, capture N words, drain them byte-by-byte to a transmitter.
//  Sits between the host command decoder and DataStorage/UART TX, in the storage read-clock domain.
// PARAMETERS
//  LEN_W          16     width of CaptureLength and word counter
//  CLEAR_CYCLES   8      cycles StorageReset is held high during CLEAR (>=1)
//  TIMEOUT_CYCLES 65535  DRAIN cycles without a byte accepted before abort (>=2)
// PORTS
//  Clock             in   1      sole clock; all logic on posedge
//  Reset_n           in   1      asynchronous, active-low reset
//  Arm               in   1      1-cycle start request; ignored unless IDLE
//  Abort             in   1      1-cycle abort; any state -> IDLE, Error=0
//  Trigger           in   1      level; capture starts on 0->1 edge seen in ARMED
//  CaptureLength     in   LEN_W  words to capture, sampled on accepted Arm; 0 treated as 1
//  StorageNotFull    in   1      DataStorage FifoNotFull
//  StorageDataReady  in   1      DataStorage DataReadyToSend (converter not empty)
//  StorageDataValid  in   1      DataStorage DataValid (byte valid, 1 cycle after read)
//  StorageData       in   8      DataStorage DataOut
//  StorageReset      out  1      drives DataStorage Reset
//  CaptureEnable     out  1      drives DataStorage WriteEnable
//  StorageReadEnable out  1      drives DataStorage ReadEnable
//  TxData            out  8      byte to transmitter, stable while TxValid
//  TxValid           out  1      byte offered; held until TxReady
//  TxReady           in   1      transmitter accepts when TxValid&&TxReady
//  Busy              out  1      1 in every state except IDLE
//  Done              out  1      1-cycle pulse on successful completion
//  Error             out  1      sticky timeout flag; cleared on accepted Arm
//  Truncated         out  1      sticky: capture ended early on full; cleared on accepted Arm
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; TxData 8'h00.
//  States: IDLE, CLEAR, ARMED, CAPTURE, DRAIN, DONE; all outputs registered.
//  IDLE: on Arm -> CLEAR; latch Len=max(CaptureLength,1); clear Error and Truncated.
//  CLEAR: StorageReset=1 for exactly CLEAR_CYCLES cycles -> ARMED.
//  ARMED: register Trigger; on prev=0 && cur=1 -> CAPTURE. A Trigger high on ARMED entry does not fire.
//  CAPTURE:
//   - CaptureEnable=1; WordCnt++ each cycle CaptureEnable&&StorageNotFull.
//   - Counting cycle with WordCnt==Len-1: CaptureEnable drops next cycle -> DRAIN.
//   - StorageNotFull=0 before Len reached: Truncated=1 -> DRAIN, WordCnt frozen.
//  DRAIN:
//   - Target = 4*WordCnt bytes, LEN_W+2 bits, no overflow.
//   - StorageReadEnable is a 1-cycle pulse, issued only if StorageDataReady, no read outstanding, TxValid=0.
//   - StorageDataValid (next cycle) loads TxData, sets TxValid; ByteCnt++ on TxValid&&TxReady.
//   - Max one outstanding byte. StorageDataValid without a pending read is ignored.
//   - ByteCnt==Target after acceptance -> DONE.
//   - Timeout counter resets on each accepted byte. At TIMEOUT_CYCLES: Error=1, TxValid=0 -> IDLE.
//  DONE: Done=1 one cycle -> IDLE.
//  Abort wins over every other transition in the same cycle. Next cycle: IDLE, Busy/TxValid/enables 0.
//  Abort in IDLE has no effect. Arm while Busy is ignored; Arm and Abort together in IDLE: Abort wins.
//  Reset_n low mid-operation: immediate return to reset values, no Done pulse.
// TESTING
//  1 Arm Len=4, Trigger rise, NotFull=1, TxReady=1 -> CLEAR 8 cyc, CaptureEnable 4 cyc, 16 bytes in order, Done 1 pulse.
//  2 Trigger held high before Arm -> stays ARMED until Trigger falls and rises again.
//  3 Len=100, StorageNotFull drops after 37 counted words -> Truncated=1, 148 bytes sent, Done=1.
//  4 TxReady=0 for 10 cycles mid-drain -> TxData stable, no StorageReadEnable issued, no byte lost.
//  5 TIMEOUT_CYCLES=16, StorageDataReady stuck 0 in DRAIN -> Error=1 at cycle 16, IDLE, Done=0.
//  6 Abort during CAPTURE and DRAIN; Reset_n pulse mid-CAPTURE -> IDLE next cycle, all outputs 0; CaptureLength=0 -> 4 bytes.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs one ADC capture through DataStorage -- clear, arm, wait for trigger,
// capture N words, then drain them byte-by-byte to the transmitter. All outputs are registered.
module capture_sequencer #(
    parameter int LEN_W          = 16,
    parameter int CLEAR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Arm,
    input  logic             Abort,
    input  logic             Trigger,
    input  logic [LEN_W-1:0] CaptureLength,
    input  logic             StorageNotFull,
    input  logic             StorageDataReady,
    input  logic             StorageDataValid,
    input  logic [7:0]       StorageData,
    output logic             StorageReset,
    output logic             CaptureEnable,
    output logic             StorageReadEnable,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic             Truncated
);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {StIdle, StClear, StArmed, StCapture, StDrain, StDone} stateType;
    stateType         state, stateNext;
    logic [LEN_W-1:0] len, lenNext, wordCnt, wordCntNext;
    logic [LEN_W+1:0] byteCnt, byteCntNext, target;
    logic [CLR_W-1:0] clearCnt, clearCntNext;
    logic [TO_W-1:0]  timeoutCnt, timeoutCntNext;
    logic             trigPrev, trigPrevNext, readPending, readPendingNext, accept;
    logic             readEnableNext, txValidNext, errorNext, truncatedNext;
    logic [7:0]       txDataNext;
    assign accept = TxValid && TxReady;
    assign target = {wordCnt, 2'b00};
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state             <= StIdle;
            len               <= '0;
            wordCnt           <= '0;
            byteCnt           <= '0;
            clearCnt          <= '0;
            timeoutCnt        <= '0;
            trigPrev          <= 1'b0;
            readPending       <= 1'b0;
            StorageReset      <= 1'b0;
            CaptureEnable     <= 1'b0;
            StorageReadEnable <= 1'b0;
            TxData            <= 8'h00;
            TxValid           <= 1'b0;
            Busy              <= 1'b0;
            Done              <= 1'b0;
            Error             <= 1'b0;
            Truncated         <= 1'b0;
        end else begin
            state             <= stateNext;
            len               <= lenNext;
            wordCnt           <= wordCntNext;
            byteCnt           <= byteCntNext;
            clearCnt          <= clearCntNext;
            timeoutCnt        <= timeoutCntNext;
            trigPrev          <= trigPrevNext;
            readPending       <= readPendingNext;
            StorageReset      <= stateNext == StClear;
            CaptureEnable     <= stateNext == StCapture;
            StorageReadEnable <= readEnableNext;
            TxData            <= txDataNext;
            TxValid           <= txValidNext;
            Busy              <= stateNext != StIdle;
            Done              <= stateNext == StDone;
            Error             <= errorNext;
            Truncated         <= truncatedNext;
        end
    end
    always_comb begin
        stateNext       = state;
        lenNext         = len;
        wordCntNext     = wordCnt;
        byteCntNext     = byteCnt;
        clearCntNext    = '0;
        timeoutCntNext  = '0;
        trigPrevNext    = Trigger;
        readPendingNext = readPending;
        readEnableNext  = 1'b0;
        txDataNext      = TxData;
        txValidNext     = TxValid;
        errorNext       = Error;
        truncatedNext   = Truncated;
        case (state)
            StIdle: begin
                if (Arm && !Abort) begin
                    stateNext       = StClear;
                    lenNext         = (CaptureLength == '0) ? LEN_W'(1) : CaptureLength;
                    wordCntNext     = '0;
                    byteCntNext     = '0;
                    readPendingNext = 1'b0;
                    txValidNext     = 1'b0;
                    errorNext       = 1'b0;
                    truncatedNext   = 1'b0;
                end
            end
            StClear: begin
                clearCntNext = clearCnt + CLR_W'(1);
                // Forcing trigPrev high means a Trigger already high on ARMED entry cannot fire.
                if (clearCnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                    stateNext    = StArmed;
                    trigPrevNext = 1'b1;
                end
            end
            StArmed: stateNext = (!trigPrev && Trigger) ? StCapture : StArmed;
            StCapture: begin
                if (!StorageNotFull) begin
                    truncatedNext = 1'b1;
                    stateNext     = StDrain;
                end else begin
                    wordCntNext = wordCnt + LEN_W'(1);
                    stateNext   = (wordCnt == len - LEN_W'(1)) ? StDrain : StCapture;
                end
            end
            StDrain: begin
                byteCntNext    = byteCnt + (LEN_W+2)'(accept);
                timeoutCntNext = accept ? '0 : timeoutCnt + TO_W'(1);
                txValidNext    = TxValid && !TxReady;
                if (readPending && StorageDataValid) begin
                    txDataNext      = StorageData;
                    txValidNext     = 1'b1;
                    readPendingNext = 1'b0;
                end
                // A zero-word (truncated-at-start) capture completes without any byte.
                if (byteCntNext == target) begin
                    stateNext = StDone;
                end else if (!accept && timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    stateNext       = StIdle;
                    errorNext       = 1'b1;
                    txValidNext     = 1'b0;
                    readPendingNext = 1'b0;
                end else if (StorageDataReady && !readPending && !TxValid) begin
                    readEnableNext  = 1'b1;
                    readPendingNext = 1'b1;
                end
            end
            StDone: stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
        if (Abort && state != StIdle) begin
            stateNext       = StIdle;
            readEnableNext  = 1'b0;
            readPendingNext = 1'b0;
            txValidNext     = 1'b0;
            errorNext       = 1'b0;
        end
    end
endmodule
